// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types for the trace commit scheduler
package trace_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] dnpc;
    logic        kill;
    logic        invalid;
  } trace_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - DEPTH-entry FIFO with two ordered write ports and one read port
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0,
  input  trace_entry_t           data0,
  input  logic                   push1,
  input  trace_entry_t           data1,
  input  logic                   pop,
  output trace_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr1;
  logic [AW-1:0]  wr_addr1;
  logic [1:0]     n_push;

  assign wr_ptr1  = wr_ptr + AW'(1);
  // port 1 lands behind port 0 when both write, otherwise takes the tail slot
  assign wr_addr1 = push0 ? wr_ptr1 : wr_ptr;
  assign n_push   = {push0 & push1, push0 ^ push1};
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]   <= data0;
    if (push1) mem[wr_addr1] <= data1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

endmodule

// File: rtl/trace_commit_sched.sv
// rtl/trace_commit_sched.sv - merges commit and flush events into the trace sink and sequences halt
module trace_commit_sched
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_inst,
  input  logic [63:0] wb_dnpc,
  input  logic        wb_invalid,
  input  logic        flush_valid,
  output logic        flush_ready,
  input  logic [63:0] flush_dnpc,
  output logic        out_en,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_dnpc,
  output logic        out_kill,
  output logic        out_invalid,
  output logic [63:0] retired_cnt,
  output logic        halt
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_e  state;
  logic [CW-1:0] count;
  trace_entry_t  head;
  trace_entry_t  wb_entry;
  trace_entry_t  fl_entry;
  logic          wb_acc;
  logic          fl_acc;
  logic          pop;
  logic [63:0]   retired_q;
  logic          halt_q;

  // commit needs two free slots so a same-cycle flush can never be refused
  assign wb_ready    = (state == RUN) && ((CW'(DEPTH) - count) >= CW'(2));
  assign flush_ready = (state == RUN) && (count < CW'(DEPTH));

  assign wb_acc = wb_valid & wb_ready;
  assign fl_acc = flush_valid & flush_ready;

  assign wb_entry = '{inst: wb_inst, dnpc: wb_dnpc, kill: 1'b0, invalid: wb_invalid};
  assign fl_entry = '{inst: 32'd0, dnpc: flush_dnpc, kill: 1'b1, invalid: 1'b0};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (wb_acc),
    .data0 (wb_entry),
    .push1 (fl_acc),
    .data1 (fl_entry),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign out_en      = (count != '0);
  assign pop         = out_en & out_ready;
  assign out_inst    = out_en ? head.inst    : 32'd0;
  assign out_dnpc    = out_en ? head.dnpc    : 64'd0;
  assign out_kill    = out_en ? head.kill    : 1'b0;
  assign out_invalid = out_en ? head.invalid : 1'b0;
  assign retired_cnt = retired_q;
  assign halt        = halt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      halt_q    <= 1'b0;
      retired_q <= 64'd0;
    end else begin
      if (pop && !head.kill) retired_q <= retired_q + 64'd1;
      case (state)
        RUN:   if (wb_acc && wb_invalid) state <= DRAIN;
        DRAIN: if (pop && head.invalid) begin
          state  <= HALT;
          halt_q <= 1'b1;
        end
        HALT:  halt_q <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_commit_sched.sv
// tb/tb_trace_commit_sched.sv - directed self-checking bench for trace_commit_sched
module tb_trace_commit_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [31:0] wb_inst = 32'd0;
  logic [63:0] wb_dnpc = 64'd0;
  logic        wb_invalid = 1'b0;
  logic        flush_valid = 1'b0;
  logic        flush_ready;
  logic [63:0] flush_dnpc = 64'd0;
  logic        out_en;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [63:0] out_dnpc;
  logic        out_kill;
  logic        out_invalid;
  logic [63:0] retired_cnt;
  logic        halt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_commit_sched #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_inst     (wb_inst),
    .wb_dnpc     (wb_dnpc),
    .wb_invalid  (wb_invalid),
    .flush_valid (flush_valid),
    .flush_ready (flush_ready),
    .flush_dnpc  (flush_dnpc),
    .out_en      (out_en),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_dnpc    (out_dnpc),
    .out_kill    (out_kill),
    .out_invalid (out_invalid),
    .retired_cnt (retired_cnt),
    .halt        (halt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    #2;
    total++;
    if ({out_en, out_inst, out_dnpc, out_kill, out_invalid} !== 99'd0) begin
      bad++; $display("FAIL reset_out got=%0b/%h/%h exp=0", out_en, out_inst, out_dnpc);
    end
    total++;
    if ({wb_ready, flush_ready, halt, retired_cnt} !== {3'b110, 64'd0}) begin
      bad++; $display("FAIL reset_ctl got=%b%b%b cnt=%0d exp=110 cnt=0", wb_ready, flush_ready, halt, retired_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_inst = 32'h0000_0013; wb_dnpc = 64'h8000_0004; wb_invalid = 1'b0;
    @(negedge clk);
    wb_valid = 1'b0;
    total++;
    if ({out_en, out_inst, out_dnpc, out_kill, out_invalid} !== {1'b1, 32'h13, 64'h8000_0004, 2'b00}) begin
      bad++; $display("FAIL single_out got=%0b %h %h %0b exp=1 00000013 80000004 0", out_en, out_inst, out_dnpc, out_kill);
    end
    @(negedge clk);
    total++;
    if ({out_en, retired_cnt} !== {1'b0, 64'd1}) begin
      bad++; $display("FAIL single_cnt got=%0b %0d exp=0 1", out_en, retired_cnt);
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    wb_valid = 1'b1; wb_inst = 32'h0000_0033; wb_dnpc = 64'h8000_0008;
    flush_valid = 1'b1; flush_dnpc = 64'h8000_0100;
    @(negedge clk);
    wb_valid = 1'b0; flush_valid = 1'b0;
    total++;
    if ({out_en, out_inst, out_dnpc, out_kill} !== {1'b1, 32'h33, 64'h8000_0008, 1'b0}) begin
      bad++; $display("FAIL pair_commit got=%0b %h %h %0b exp=1 00000033 80000008 0", out_en, out_inst, out_dnpc, out_kill);
    end
    @(negedge clk);
    total++;
    if ({out_en, out_inst, out_dnpc, out_kill, out_invalid} !== {1'b1, 32'h0, 64'h8000_0100, 2'b10}) begin
      bad++; $display("FAIL pair_flush got=%0b %h %h %0b exp=1 00000000 80000100 1", out_en, out_inst, out_dnpc, out_kill);
    end
    @(negedge clk);
    total++;
    if ({out_en, retired_cnt} !== {1'b0, 64'd2}) begin
      bad++; $display("FAIL pair_cnt got=%0b %0d exp=0 2", out_en, retired_cnt);
    end
  endtask

  task automatic test_full;
    logic [31:0] exp_inst;
    logic [63:0] exp_dnpc;
    logic        exp_kill;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (wb_ready !== 1'b1) begin
        bad++; $display("FAIL full_wb_ready_%0d got=%b exp=1", i, wb_ready);
      end
      wb_valid = 1'b1; wb_inst = 32'h100 + i; wb_dnpc = 64'h8000_1000 + 64'(4 * i);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    total++;
    if ({wb_ready, flush_ready} !== 2'b01) begin
      bad++; $display("FAIL full_cnt3_ready got=%b%b exp=01", wb_ready, flush_ready);
    end
    flush_valid = 1'b1; flush_dnpc = 64'h8000_2000;
    @(negedge clk);
    flush_valid = 1'b0;
    total++;
    if ({wb_ready, flush_ready} !== 2'b00) begin
      bad++; $display("FAIL full_cnt4_ready got=%b%b exp=00", wb_ready, flush_ready);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_inst = (j < 3) ? 32'h100 + j : 32'h0;
      exp_dnpc = (j < 3) ? 64'h8000_1000 + 64'(4 * j) : 64'h8000_2000;
      exp_kill = (j == 3);
      total++;
      if ({out_en, out_inst, out_dnpc, out_kill} !== {1'b1, exp_inst, exp_dnpc, exp_kill}) begin
        bad++; $display("FAIL full_order_%0d got=%0b %h %h %0b exp=1 %h %h %0b", j, out_en, out_inst, out_dnpc, out_kill, exp_inst, exp_dnpc, exp_kill);
      end
      @(negedge clk);
    end
    total++;
    if ({out_en, retired_cnt} !== {1'b0, 64'd5}) begin
      bad++; $display("FAIL full_cnt got=%0b %0d exp=0 5", out_en, retired_cnt);
    end
  endtask

  task automatic test_halt;
    out_ready = 1'b0;
    @(negedge clk);
    wb_valid = 1'b1; wb_inst = 32'h300; wb_dnpc = 64'h8000_3000; wb_invalid = 1'b0;
    @(negedge clk);
    wb_inst = 32'h301; wb_dnpc = 64'h8000_3004;
    @(negedge clk);
    total++;
    if (wb_ready !== 1'b1) begin
      bad++; $display("FAIL halt_pre_ready got=%b exp=1", wb_ready);
    end
    wb_inst = 32'h302; wb_dnpc = 64'h8000_3008; wb_invalid = 1'b1;
    @(negedge clk);
    wb_inst = 32'h3ff; wb_invalid = 1'b0;
    flush_valid = 1'b1; flush_dnpc = 64'h8000_3fff;
    total++;
    if ({wb_ready, flush_ready, halt} !== 3'b000) begin
      bad++; $display("FAIL drain_ready got=%b%b%b exp=000", wb_ready, flush_ready, halt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({out_en, out_inst, out_invalid, halt} !== {1'b1, 32'h300 + k, (k == 2), 1'b0}) begin
        bad++; $display("FAIL drain_pop_%0d got=%0b %h %0b %0b exp=1 %h %0b 0", k, out_en, out_inst, out_invalid, halt, 32'h300 + k, (k == 2));
      end
      @(negedge clk);
    end
    total++;
    if ({halt, out_en, retired_cnt} !== {2'b10, 64'd8}) begin
      bad++; $display("FAIL halt_rise got=%0b %0b %0d exp=1 0 8", halt, out_en, retired_cnt);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({halt, out_en, wb_ready, flush_ready} !== 4'b1000) begin
      bad++; $display("FAIL halt_sticky got=%b%b%b%b exp=1000", halt, out_en, wb_ready, flush_ready);
    end
    wb_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wb_valid = 1'b1; wb_inst = 32'h500 + i; wb_dnpc = 64'h8000_5000 + 64'(4 * i);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    total++;
    if ({out_en, dut.u_fifo.count} !== {1'b1, 3'd3}) begin
      bad++; $display("FAIL midop_queued got=%0b %0d exp=1 3", out_en, dut.u_fifo.count);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out_en, dut.u_fifo.count, retired_cnt, out_inst, wb_ready, flush_ready, halt} !== {1'b0, 3'd0, 64'd0, 32'd0, 3'b110}) begin
      bad++; $display("FAIL midop_async got=%0b %0d %0d %h %b%b%b exp=0 0 0 0 110", out_en, dut.u_fifo.count, retired_cnt, out_inst, wb_ready, flush_ready, halt);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_inst = 32'h600; wb_dnpc = 64'h8000_6000;
    @(negedge clk);
    wb_valid = 1'b0;
    total++;
    if ({out_en, out_inst, out_dnpc} !== {1'b1, 32'h600, 64'h8000_6000}) begin
      bad++; $display("FAIL midop_after got=%0b %h %h exp=1 00000600 80006000", out_en, out_inst, out_dnpc);
    end
    @(negedge clk);
    total++;
    if ({out_en, retired_cnt} !== {1'b0, 64'd1}) begin
      bad++; $display("FAIL midop_cnt got=%0b %0d exp=0 1", out_en, retired_cnt);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_inst = 32'h700; wb_dnpc = 64'h8000_7000;
    @(negedge clk);
    wb_valid = 1'b0;
    force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    total++;
    if ({out_en, retired_cnt} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      bad++; $display("FAIL wrap_preset got=%0b %h exp=1 ffffffffffffffff", out_en, retired_cnt);
    end
    @(negedge clk);
    total++;
    if ({out_en, retired_cnt} !== {1'b0, 64'd0}) begin
      bad++; $display("FAIL wrap_zero got=%0b %h exp=0 0", out_en, retired_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_same_cycle;
    test_full;
    test_halt;
    test_reset_midop;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
